// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } ifq_state_e;

    localparam int          IFQ_INSTR_W = 32;
    localparam logic [31:0] PC_STEP     = 32'd4;
    localparam logic [31:0] NOP         = 32'h0;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with flush; holds {pc, instr} prefetch entries.
module ifq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_N);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetch into a prefetch queue with redirect/flush.
// Define IFQ_PERF_EN to add saturating perf_fetched/perf_flushed counters.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int          ADDR_W   = 5,
    parameter int          INSTR_W  = IFQ_INSTR_W,
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
    input  logic               stop,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc,
`ifdef IFQ_PERF_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed,
`endif
    output logic               busy
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int FW = 32 + INSTR_W;
    localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

    ifq_state_e         state;
    ifq_state_e         state_nxt;
    logic [31:0]        pc;
    logic [31:0]        pc_inc;
    logic               epoch;
    logic               rd_valid;
    logic               rd_epoch;
    logic [31:0]        rd_pc;
    logic [INSTR_W-1:0] rd_data;
    logic [INSTR_W-1:0] mem [2**ADDR_W];
    logic [CW-1:0]      count;
    logic [CW:0]        occ;
    logic               full;
    logic               empty;
    logic [FW-1:0]      head;
    logic               push;
    logic               pop;
    logic               flush;
    logic               issue;
    logic               redir;
    logic               launch;
    logic               unused_ok;

    assign unused_ok = ^{redirect_pc[1:0], full};

    assign occ    = {1'b0, count} + {{CW{1'b0}}, rd_valid};
    assign pc_inc = (&pc[ADDR_W+1:2]) ? 32'h0 : pc + PC_STEP;
    assign launch = (state == IDLE) && start && !stop;

    always_comb begin
        state_nxt = state;
        flush     = 1'b0;
        issue     = 1'b0;
        redir     = 1'b0;
        unique case (state)
            IDLE: begin
                if (launch)
                    state_nxt = FETCH;
            end
            FETCH: begin
                unique case (1'b1)
                    stop: begin
                        state_nxt = IDLE;
                        flush     = 1'b1;
                    end
                    redirect_valid && !stop: begin
                        redir = 1'b1;
                        flush = 1'b1;
                    end
                    default: issue = (occ < QD);
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            epoch    <= 1'b0;
            rd_valid <= 1'b0;
            rd_epoch <= 1'b0;
            rd_pc    <= '0;
        end else begin
            state    <= state_nxt;
            rd_valid <= issue;
            if (launch)
                pc <= RESET_PC;
            else if (redir)
                pc <= {redirect_pc[31:2], 2'b00};
            else if (issue)
                pc <= pc_inc;
            if (redir)
                epoch <= ~epoch;
            if (issue) begin
                rd_pc    <= pc;
                rd_epoch <= epoch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && load_en)
            mem[load_addr] <= load_data;
        if (issue)
            rd_data <= mem[pc[ADDR_W+1:2]];
    end

    // Reads tagged with an older epoch belong to a squashed path.
    assign push = rd_valid && (rd_epoch == epoch) && !flush;
    assign pop  = out_valid && out_ready;

    ifq_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata ({rd_pc, rd_data}),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;
    assign out_pc    = empty ? 32'h0 : head[FW-1 -: 32];
    assign out_instr = empty ? INSTR_W'(NOP) : head[INSTR_W-1:0];
    assign busy      = (state == FETCH);

`ifdef IFQ_PERF_EN
    logic [31:0] drop_n;
    logic [32:0] fetched_sum;
    logic [32:0] flushed_sum;

    always_comb begin
        drop_n      = 32'(count) - 32'(pop) + 32'(rd_valid);
        fetched_sum = {1'b0, perf_fetched} + {32'h0, pop};
        flushed_sum = {1'b0, perf_flushed} + (flush ? {1'b0, drop_n} : 33'h0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
            perf_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end
`endif

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Parametrised successor to the single-port instruction fetch stage. It holds a loadable instruction memory of configurable depth and fetches sequentially from a programmable reset PC into a prefetch queue. Instructions go to decode over a valid/ready handshake. It supports branch redirect with flush, a start/stop control, and PC wrap-around. It sits between the program loader and the decode stage.

Parameters:
ADDR_W, 5, word-address width; memory depth = 2**ADDR_W words
INSTR_W, 32, instruction width
QDEPTH, 4, prefetch queue entries (power of two, ≥2)
RESET_PC, 32'h0, PC loaded on reset and on start

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
load_en  in  1  write load_data to memory word load_addr (honoured only in IDLE)
load_addr  in  ADDR_W  memory word address
load_data  in  INSTR_W  memory write data
start  in  1  IDLE->FETCH pulse
stop  in  1  return to IDLE, flush
redirect_valid  in  1  branch redirect request
redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  INSTR_W  head instruction
out_pc  out  32  byte PC of head instruction
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; pc = RESET_PC; queue empty; no read in flight; out_valid = 0, out_instr = 0, out_pc = 0, busy = 0. Memory contents are not cleared.
- States: IDLE, FETCH.
  - IDLE -> FETCH on start; pc reloads RESET_PC.
  - FETCH -> IDLE on stop: flush queue, drop in-flight read.
  - stop has priority over start and redirect.
- Memory: synchronous read, 1-cycle latency. Read index = pc[ADDR_W+1:2].
- Load: write on a load_en edge only in IDLE. load_en in FETCH is ignored.
- Issue rule (FETCH): issue a read when count + inflight < QDEPTH, then pc += 4.
  - PC wraps modulo 2**(ADDR_W+2); upper pc bits are zeroed on wrap.
- Enqueue: read data enqueues with its PC on the following edge.
- Handshake: a transfer occurs when out_valid && out_ready. out_valid is registered, with no combinational path from out_ready. out_instr and out_pc hold stable while out_valid && !out_ready.
- Simultaneous push and pop when full is allowed: count is unchanged. The queue never overflows.
- Latency: start or redirect sampled at edge N -> read issued at N+1 -> out_valid high after edge N+2. With out_ready held at 1, throughput is one instruction per cycle.
- Redirect (FETCH only, ignored in IDLE):
  - Flush the queue and squash the in-flight read via a 1-bit epoch tag.
  - pc = {redirect_pc[31:2], 2'b00}.
  - A handshake completing in the redirect cycle counts as delivered.
  - No stale instruction may appear after the redirect.
- Back-to-back redirects: the last one wins. Each squashes all older fetches.
- rst mid-operation overrides everything on that edge.

Optional Feature:
Macro IFQ_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] (handshakes completed) and perf_flushed[31:0] (entries plus in-flight reads discarded by redirect or stop). Both cleared by rst, saturate at all-ones.
- Undefined: ports and counters absent; otherwise identical behaviour.

Decomposition:
- Package ifq_pkg: state enum (IDLE, FETCH), INSTR_W default, PC_STEP = 4, NOP encoding 32'h0.
- One sub-module, ifq_fifo: synchronous FIFO of {pc, instr}, parametrised by depth and width, with flush input, count, full/empty.

Test Plan:
1. Load words 0..31 with i*3+1 in IDLE, start, out_ready=1 -> out_valid rises 2 cycles after start; instrs 1, 4, 7, ... with PCs 0, 4, 8; one per cycle.
2. Run past word 31 -> after PC 0x7C, next out_pc = 0x0 with instr 1 (wrap).
3. Toggle out_ready 1,0,0,1 -> during stalls out_instr/out_pc held; no loss or duplication; queue never exceeds QDEPTH.
4. Redirect to 0x43 while queue is full -> next delivered out_pc = 0x40, instr = word 16 value (49); no older PC after.
5. Assert load_en in FETCH to word 0 with 0xDEADBEEF, then stop, start -> first instr still 1; repeat the load in IDLE -> first instr 0xDEADBEEF.
6. rst during FETCH with out_valid=1 -> next cycle out_valid=0, busy=0; start -> refetch from RESET_PC.
